npu_img_row_loader: RTL
=======================

NPU_IMG_ROW_LOADER -- requirements
Module: npu_img_row_loader

Interface
REQ-001 The block SHALL have parameter ROW_BYTES, default 64, giving the image row length in bytes.
REQ-002 The block SHALL have parameter NUM_ROWS, default 64, giving the number of rows per frame.
REQ-003 The block SHALL have parameter IMG_BASE, default 32'h0000_0000, giving the NPU RGB memory base address.
REQ-004 The block SHALL have parameter ROW_CMD_ADDR, default 32'h0000_2000, giving the NPU write_row control register address.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (sole clock, all state on rising edge); resetn input 1 (asynchronous assert, active-low).
REQ-006 The pixel stream input SHALL be: pix_valid_i input 1 (pixel valid); pix_sof_i input 1 (first pixel of frame, qualified by pix_valid_i); pix_data_i input 8 (pixel byte); pix_ready_o output 1 (pixel accepted when valid and ready).
REQ-007 The AHB-Lite master outputs SHALL be: ahb_m_haddr_o 32; ahb_m_hwrite_o 1; ahb_m_hsize_o 3; ahb_m_hburst_o 3; ahb_m_hprot_o 4; ahb_m_htrans_o 2; ahb_m_hmastlock_o 1; ahb_m_hwdata_o 32.
REQ-008 The AHB-Lite master inputs SHALL be: ahb_m_hready_i 1; ahb_m_hresp_i 1.
REQ-009 The status outputs SHALL be: busy_o 1 (frame in progress); rows_sent_o 6 (rows committed this frame); frame_done_p_o 1 (one-cycle pulse after last row command); err_o 1 (sticky bus error).

Function
REQ-010 The FSM SHALL have the states IDLE, FILL, WR_ADDR, WR_DATA, CMD_ADDR, CMD_DATA; reset state is IDLE.
REQ-011 IDLE: pix_ready_o=1; an accepted pixel with pix_sof_i=1 SHALL be stored at column 0 and move the FSM to FILL; accepted pixels without pix_sof_i SHALL be dropped.
REQ-012 FILL: pix_ready_o=1; each accepted pixel SHALL be written to the internal ROW_BYTES x 8 row buffer at the column counter; when column ROW_BYTES-1 is accepted, the FSM SHALL go to WR_ADDR with pix_ready_o=0 from the next cycle.
REQ-013 WR_ADDR SHALL drive htrans=NONSEQ, hwrite=1, hburst=SINGLE, hprot=4'b0011, hmastlock=0, and haddr=IMG_BASE+row*ROW_BYTES+col, holding these until hready=1, then go to WR_DATA.
REQ-014 WR_DATA SHALL drive htrans=IDLE and hwdata; on hready=1 it SHALL advance col, returning to WR_ADDR, or, after the last column, go to CMD_ADDR.
REQ-015 In byte mode, hsize SHALL be 3'b000 and hwdata SHALL replicate the byte on all four lanes.
REQ-016 CMD_ADDR/CMD_DATA SHALL perform a single word write (hsize=3'b010) of 32'h0000_0001 to ROW_CMD_ADDR; on completion rows_sent_o SHALL increment.
REQ-017 If rows_sent_o then equals NUM_ROWS, the block SHALL pulse frame_done_p_o, clear rows_sent_o next cycle and go to IDLE; otherwise it SHALL go to FILL.
REQ-018 htrans SHALL be IDLE in every state other than WR_ADDR and CMD_ADDR; no transfers are pipelined.
REQ-019 In FILL, an accepted pixel with pix_sof_i=1 SHALL discard the partial row, zero rows_sent_o and store the pixel at column 0 (frame restart).
REQ-020 Any data phase with hready=1 and hresp=1 SHALL set err_o, abort the frame, zero the counters and go to IDLE.
REQ-021 err_o SHALL clear only on reset or on acceptance of the next SOF pixel.
REQ-022 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-023 While resetn=0, the block SHALL hold the FSM at IDLE and all outputs at 0, except pix_ready_o=1 and hburst=0.
REQ-024 Reset asserted mid-transfer SHALL abandon the transfer immediately; row buffer contents are don't-care after reset.

Configuration
REQ-025 Macro NPU_ROW_LOADER_WORD_PACK_EN SHALL select the write mode: when defined, WR phases issue word writes (hsize=3'b010) of 4 packed bytes (byte col+k in hwdata[8k+7:8k]), col advances by 4, and ROW_BYTES must be a multiple of 4; when undefined, byte mode per REQ-015 applies.

Verification
REQ-026 The bench SHALL cover: SOF plus 64 pixels with hready held 1 (byte mode) -> 64 byte writes to 0x000..0x03F, then write 0x1 to 0x2000, rows_sent_o=1.
REQ-027 The bench SHALL cover: a full frame of 64x64 pixels -> 64 row commands and frame_done_p_o high for exactly one cycle, after which busy_o=0 and rows_sent_o=0.
REQ-028 The bench SHALL cover: hready=0 for 3 cycles during a WR_ADDR of row 2, col 5 -> haddr held at 0x085 and no double write.
REQ-029 The bench SHALL cover: hresp=1 on the 10th data phase -> err_o=1 and FSM in IDLE; a non-SOF pixel is dropped; an SOF pixel then clears err_o.
REQ-030 The bench SHALL cover: SOF re-asserted after 20 pixels of row 3 -> rows_sent_o=0 and the next row written at IDLE-relative address 0x000.
REQ-031 The bench SHALL cover: with NPU_ROW_LOADER_WORD_PACK_EN defined, pixels 0x00..0x3F -> 16 word writes, the first hwdata=32'h0302_0100 at 0x000.

Source files
------------

// File: rtl/npu_img_row_loader.sv
// Buffers one image row from a pixel stream, then writes it to NPU memory over AHB-Lite.
// Define NPU_ROW_LOADER_WORD_PACK_EN to pack 4 bytes per word write instead of byte writes.
module npu_img_row_loader #(
    parameter int unsigned ROW_BYTES    = 64,
    parameter int unsigned NUM_ROWS     = 64,
    parameter logic [31:0] IMG_BASE     = 32'h0000_0000,
    parameter logic [31:0] ROW_CMD_ADDR = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pix_valid_i,
    input  logic        pix_sof_i,
    input  logic [7:0]  pix_data_i,
    output logic        pix_ready_o,
    output logic [31:0] ahb_m_haddr_o,
    output logic        ahb_m_hwrite_o,
    output logic [2:0]  ahb_m_hsize_o,
    output logic [2:0]  ahb_m_hburst_o,
    output logic [3:0]  ahb_m_hprot_o,
    output logic [1:0]  ahb_m_htrans_o,
    output logic        ahb_m_hmastlock_o,
    output logic [31:0] ahb_m_hwdata_o,
    input  logic        ahb_m_hready_i,
    input  logic        ahb_m_hresp_i,
    output logic        busy_o,
    output logic [5:0]  rows_sent_o,
    output logic        frame_done_p_o,
    output logic        err_o
);

    localparam int unsigned CW = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
`ifdef NPU_ROW_LOADER_WORD_PACK_EN
    localparam int unsigned STEP    = 4;
    localparam logic [2:0]  WR_SIZE = 3'b010;
`else
    localparam int unsigned STEP    = 1;
    localparam logic [2:0]  WR_SIZE = 3'b000;
`endif
    localparam logic [CW-1:0] LAST_PIX   = CW'(ROW_BYTES - 1);
    localparam logic [CW-1:0] LAST_WR    = CW'(ROW_BYTES - STEP);
    localparam logic [CW-1:0] COL_STEP   = CW'(STEP);
    localparam logic [5:0]    LAST_ROW   = 6'(NUM_ROWS - 1);
    localparam logic [31:0]   ROW_STRIDE = 32'(ROW_BYTES);
    localparam logic [1:0]    HT_IDLE    = 2'b00;
    localparam logic [1:0]    HT_NONSEQ  = 2'b10;

    typedef enum logic [2:0] {
        IDLE, FILL, WR_ADDR, WR_DATA, CMD_ADDR, CMD_DATA
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [5:0]    rows_q, rows_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic [7:0]    row_buf_q [ROW_BYTES];

    logic          pix_acc;
    logic          pix_store;
    logic [CW-1:0] wr_col;
    logic [31:0]   wdata;

    assign pix_acc   = pix_valid_i && pix_ready_o;
    // Outside FILL only a SOF pixel may start a row; everything else is dropped.
    assign pix_store = pix_acc && ((state_q == FILL) || pix_sof_i);
    assign wr_col    = pix_sof_i ? '0 : col_q;

    always_ff @(posedge clk) begin
        if (pix_store) begin
            row_buf_q[wr_col] <= pix_data_i;
        end
    end

    always_comb begin
        wdata = '0;
`ifdef NPU_ROW_LOADER_WORD_PACK_EN
        for (int k = 0; k < 4; k++) begin
            wdata[8*k +: 8] = row_buf_q[col_q + CW'(k)];
        end
`else
        wdata = {4{row_buf_q[col_q]}};
`endif
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        rows_d  = rows_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE, FILL: begin
                if (pix_store) begin
                    if (pix_sof_i) begin
                        rows_d = '0;
                        err_d  = 1'b0;
                    end
                    if (wr_col == LAST_PIX) begin
                        col_d   = '0;
                        state_d = WR_ADDR;
                    end else begin
                        col_d   = wr_col + 1'b1;
                        state_d = FILL;
                    end
                end
            end
            WR_ADDR: begin
                if (ahb_m_hready_i) state_d = WR_DATA;
            end
            WR_DATA: begin
                if (ahb_m_hready_i) begin
                    if (ahb_m_hresp_i) begin
                        err_d   = 1'b1;
                        rows_d  = '0;
                        col_d   = '0;
                        state_d = IDLE;
                    end else if (col_q == LAST_WR) begin
                        col_d   = '0;
                        state_d = CMD_ADDR;
                    end else begin
                        col_d   = col_q + COL_STEP;
                        state_d = WR_ADDR;
                    end
                end
            end
            CMD_ADDR: begin
                if (ahb_m_hready_i) state_d = CMD_DATA;
            end
            CMD_DATA: begin
                if (ahb_m_hready_i) begin
                    if (ahb_m_hresp_i) begin
                        err_d   = 1'b1;
                        rows_d  = '0;
                        col_d   = '0;
                        state_d = IDLE;
                    end else if (rows_q == LAST_ROW) begin
                        // Last row of the frame: counter wraps straight to zero.
                        rows_d  = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rows_d  = rows_q + 1'b1;
                        state_d = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            col_q   <= '0;
            rows_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            rows_q  <= rows_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        pix_ready_o       = 1'b0;
        ahb_m_haddr_o     = '0;
        ahb_m_hwrite_o    = 1'b0;
        ahb_m_hsize_o     = 3'b000;
        ahb_m_hburst_o    = 3'b000;
        ahb_m_hprot_o     = 4'b0000;
        ahb_m_htrans_o    = HT_IDLE;
        ahb_m_hmastlock_o = 1'b0;
        ahb_m_hwdata_o    = '0;
        unique case (state_q)
            IDLE, FILL: pix_ready_o = 1'b1;
            WR_ADDR: begin
                ahb_m_htrans_o = HT_NONSEQ;
                ahb_m_hwrite_o = 1'b1;
                ahb_m_hsize_o  = WR_SIZE;
                ahb_m_hprot_o  = 4'b0011;
                ahb_m_haddr_o  = IMG_BASE + 32'(rows_q) * ROW_STRIDE
                               + 32'(col_q);
            end
            WR_DATA: ahb_m_hwdata_o = wdata;
            CMD_ADDR: begin
                ahb_m_htrans_o = HT_NONSEQ;
                ahb_m_hwrite_o = 1'b1;
                ahb_m_hsize_o  = 3'b010;
                ahb_m_hprot_o  = 4'b0011;
                ahb_m_haddr_o  = ROW_CMD_ADDR;
            end
            CMD_DATA: ahb_m_hwdata_o = 32'h0000_0001;
            default: ;
        endcase
    end

    assign busy_o         = (state_q != IDLE);
    assign rows_sent_o    = rows_q;
    assign err_o          = err_q;
    assign frame_done_p_o = done_q;

endmodule
